reduce_combine: RTL
===================

// Module: reduce_combine
// PURPOSE
// - Receive-side counterpart of the reduce instruction injector: consumes 76-bit fifo flits ({children, flit}) headed to this node.
// - Accumulates payloads per communicator context until all expected contributions arrive, applying the flit's op.
// - Emits one combined 73-bit flit toward root_x/y/z, with src set to this node.
// - Sits between the router ejection fifo and the injection port of the next hop up the reduction tree.
// PARAMETERS
// - FlitWidth      73  network flit width, bit 72 = valid
// - ChildrenWidth  3   width of children field, flit bits 75:73
// - PayloadWidth   32  payload bits 31:0
// - TableSize      4   reduction table entries, indexed by contextId[1:0]
// - rank_x/y/z     0   3-bit coordinates of this node, written to src of emitted flits
// - root_x/y/z     0   3-bit coordinates of the reduction root, written to dst of emitted flits
// - TimeoutCycles  255 idle-wait limit per entry; 8-bit counter, used only with REDUCE_TIMEOUT_EN
// PORTS
// - clk        in   1   clock
// - rst        in   1   asynchronous reset, active-high
// - in_flit    in   76  {children, valid, dst, src, contextId, tag, algtype, op, payload}
// - in_valid   in   1   in_flit present
// - in_ready   out  1   flit accepted on in_valid & in_ready at posedge clk
// - out_flit   out  73  combined result flit
// - out_valid  out  1   out_flit present
// - out_ready  in   1   downstream accepts out_flit on out_valid & out_ready
// - err        out  1   one-cycle pulse: tag mismatch drop, or timeout flush
// - active     out  4   per-entry busy bits
// BEHAVIOUR
// Reset (async):
// - out_valid = 0, out_flit = 0, err = 0, active = 0; every table entry is invalid.
// Handshake:
// - in_ready = !out_valid | out_ready. Single output register; no skid buffer.
// - Flits with in_flit[72] = 0 are accepted and discarded.
// Table entry fields:
// - act, tag, op, algtype, contextId, acc[31:0], remaining[3:0], wait[7:0].
// Accept to an idle entry e = contextId[1:0]:
// - Load tag, op, algtype and contextId from the flit; acc = payload; remaining = children.
// - If children == 0 (leaf), complete in the same cycle and never set act.
// Accept to an active entry:
// - Tag equal: acc = f(op, acc, payload); remaining -= 1.
// - Tag unequal: drop the flit and pulse err; the entry is unchanged.
// op encoding for f, all 32-bit and wrapping:
// - 0 SUM: unsigned wrap add.
// - 1 MAX, 2 MIN: signed compare.
// - 3 AND, 4 OR, 5 XOR.
// - 6..15: acc unchanged (first value kept).
// Completion (remaining reaches 0, or leaf):
// - Next cycle: out_valid = 1; out_flit = {1'b1, root_z, root_y, root_x, rank_z, rank_y, rank_x, contextId, tag, algtype, op, acc}; entry act cleared.
// - Latency is exactly 1 cycle from the accepting edge to out_valid.
// - out_flit holds stable until the out_valid & out_ready edge.
// - In-flight accept and output drain on the same edge are allowed; in_ready stays 1 across that edge.
// Simultaneous events:
// - A flit for an entry arriving on its completion edge opens a fresh entry on the next accept only; the table updates once per edge.
// - Only one input is processed per cycle, so at most one completion per cycle.
// Reset mid-operation:
// - All partial accumulations and the pending output are discarded; no flit is emitted.
// CONFIGURATION
// - `REDUCE_TIMEOUT_EN defined:
//   - Each active entry's wait counter increments every cycle without an accepted contribution and clears to 0 on every accepted contribution.
//   - When wait == TimeoutCycles and the output register is free, the entry emits its partial acc as a normal completion and err pulses.
//   - Priority order: an input completion, then the lowest-index timed-out entry.
//   - A timeout pending while the output is busy waits; wait saturates.
// - Undefined: no wait counters. Entries wait indefinitely; err reflects tag drops only.
// TESTING
// - Leaf: children=0, op=SUM, payload=7, ctx=1 -> out_valid next cycle, payload 7, dst=root, src=rank, active=0.
// - SUM: ctx=2, children=3, payloads 5,6,7,0xFFFFFFFF -> one flit, payload 0x00000011 (wrap), after 4th accept only.
// - MAX signed: children=2, payloads -3, 4, -9 -> payload 4; same sequence with op=MIN -> 0xFFFFFFF7.
// - Backpressure: out_ready=0 while a 2nd context completes -> in_ready=0; out_flit held; raise out_ready -> both flits emitted in order.
// - Tag mismatch: ctx=0 open with tag 0x10, then a flit with tag 0x11 -> err pulse, flit dropped, remaining unchanged.
// - Timeout (REDUCE_TIMEOUT_EN, TimeoutCycles=8): children=2, one contribution then idle -> partial emitted 8 cycles later, err=1; async rst mid-accumulation -> no output.

Source files
------------

// File: rtl/reduce_combine.sv
// reduce_combine: receive side of the tree reduction.
// Collects the contributions for each communicator context into a small table.
// When every expected contribution has arrived, it emits one combined flit
// toward the reduction root. Optional feature macro: REDUCE_TIMEOUT_EN. When it
// is defined, an entry that stays idle too long flushes its partial result and
// pulses err.
//
// Flit layout (73 bits):
//   [72] valid, [71:63] dst {z,y,x}, [62:54] src {z,y,x}, [53:46] contextId,
//   [45:38] tag, [37:36] algtype, [35:32] op, [31:0] payload
// Input flits carry children in [75:73] above the network flit.
module reduce_combine #(
  parameter int FlitWidth     = 73,
  parameter int ChildrenWidth = 3,
  parameter int PayloadWidth  = 32,
  parameter int TableSize     = 4,
  parameter logic [2:0] rank_x = 3'd0,
  parameter logic [2:0] rank_y = 3'd0,
  parameter logic [2:0] rank_z = 3'd0,
  parameter logic [2:0] root_x = 3'd0,
  parameter logic [2:0] root_y = 3'd0,
  parameter logic [2:0] root_z = 3'd0,
  parameter int TimeoutCycles  = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ChildrenWidth+FlitWidth-1:0]   in_flit,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [FlitWidth-1:0]                 out_flit,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 err,
  output logic [TableSize-1:0]                 active
);

  localparam int IdxW = $clog2(TableSize);

  // Field slices of the incoming flit
  logic [ChildrenWidth-1:0] in_children;
  logic                     in_vbit;
  logic [7:0]               in_ctx;
  logic [7:0]               in_tag;
  logic [1:0]               in_alg;
  logic [3:0]               in_op;
  logic [PayloadWidth-1:0]  in_pay;
  logic [IdxW-1:0]          idx;

  assign in_children = in_flit[75:73];
  assign in_vbit     = in_flit[72];
  assign in_ctx      = in_flit[53:46];
  assign in_tag      = in_flit[45:38];
  assign in_alg      = in_flit[37:36];
  assign in_op       = in_flit[35:32];
  assign in_pay      = in_flit[31:0];
  assign idx         = in_ctx[IdxW-1:0];

  // The incoming dst/src fields are replaced on output, so they are not needed
  logic unused_in_route;
  assign unused_in_route = ^in_flit[71:54];

  // Reduction table
  logic [TableSize-1:0]    act_reg, act_next, act_final;
  logic [7:0]              tag_reg [TableSize];
  logic [7:0]              tag_next[TableSize];
  logic [3:0]              op_reg  [TableSize];
  logic [3:0]              op_next [TableSize];
  logic [1:0]              alg_reg [TableSize];
  logic [1:0]              alg_next[TableSize];
  logic [7:0]              ctx_reg [TableSize];
  logic [7:0]              ctx_next[TableSize];
  logic [PayloadWidth-1:0] acc_reg [TableSize];
  logic [PayloadWidth-1:0] acc_next[TableSize];
  logic [3:0]              rem_reg [TableSize];
  logic [3:0]              rem_next[TableSize];

  logic                    accept;
  logic                    done;
  logic [FlitWidth-1:0]    done_flit;
  logic                    tag_drop;
  logic                    touched;
  logic [PayloadWidth-1:0] comb_acc;
  logic                    to_fire;
  logic [FlitWidth-1:0]    to_flit;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign active   = act_reg;

  function automatic logic [PayloadWidth-1:0] fold(input logic [3:0] op,
                                                   input logic [PayloadWidth-1:0] a,
                                                   input logic [PayloadWidth-1:0] b);
    case (op)
      4'd0:    fold = a + b;
      4'd1:    fold = ($signed(b) > $signed(a)) ? b : a;
      4'd2:    fold = ($signed(b) < $signed(a)) ? b : a;
      4'd3:    fold = a & b;
      4'd4:    fold = a | b;
      4'd5:    fold = a ^ b;
      default: fold = a;
    endcase
  endfunction

  function automatic logic [FlitWidth-1:0] build(input logic [7:0] ctx,
                                                 input logic [7:0] tag,
                                                 input logic [1:0] alg,
                                                 input logic [3:0] op,
                                                 input logic [PayloadWidth-1:0] acc);
    build = {1'b1, root_z, root_y, root_x, rank_z, rank_y, rank_x, ctx, tag, alg, op, acc};
  endfunction

  // Apply the accepted flit to its table entry and detect completion
  always_comb begin
    act_next  = act_reg;
    tag_next  = tag_reg;
    op_next   = op_reg;
    alg_next  = alg_reg;
    ctx_next  = ctx_reg;
    acc_next  = acc_reg;
    rem_next  = rem_reg;
    done      = 1'b0;
    done_flit = '0;
    tag_drop  = 1'b0;
    touched   = 1'b0;
    comb_acc  = fold(op_reg[idx], acc_reg[idx], in_pay);
    if (accept && in_vbit) begin
      if (!act_reg[idx]) begin
        touched = 1'b1;
        if (in_children == '0) begin
          // Leaf contribution: nothing to wait for
          done      = 1'b1;
          done_flit = build(in_ctx, in_tag, in_alg, in_op, in_pay);
        end else begin
          act_next[idx] = 1'b1;
          tag_next[idx] = in_tag;
          op_next[idx]  = in_op;
          alg_next[idx] = in_alg;
          ctx_next[idx] = in_ctx;
          acc_next[idx] = in_pay;
          rem_next[idx] = {1'b0, in_children};
        end
      end else if (tag_reg[idx] == in_tag) begin
        touched       = 1'b1;
        acc_next[idx] = comb_acc;
        rem_next[idx] = rem_reg[idx] - 4'd1;
        if (rem_reg[idx] == 4'd1) begin
          done          = 1'b1;
          act_next[idx] = 1'b0;
          done_flit     = build(ctx_reg[idx], tag_reg[idx], alg_reg[idx], op_reg[idx], comb_acc);
        end
      end else begin
        // Stale or foreign tag: drop it and leave the entry alone
        tag_drop = 1'b1;
      end
    end
  end

`ifdef REDUCE_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  logic [7:0]      wait_reg[TableSize];
  logic [IdxW-1:0] to_idx;

  // Pick the lowest-index expired entry when neither an input completion nor a busy output blocks it
  always_comb begin
    to_fire   = 1'b0;
    to_idx    = '0;
    to_flit   = '0;
    act_final = act_next;
    if (!done && in_ready) begin
      for (int i = TableSize - 1; i >= 0; i--) begin
        if (act_reg[i] && (wait_reg[i] == TimeoutLimit) && !(touched && (idx == IdxW'(i)))) begin
          to_fire = 1'b1;
          to_idx  = IdxW'(i);
        end
      end
    end
    if (to_fire) begin
      to_flit           = build(ctx_reg[to_idx], tag_reg[to_idx], alg_reg[to_idx],
                                op_reg[to_idx], acc_reg[to_idx]);
      act_final[to_idx] = 1'b0;
    end
  end

  // Idle counters: clear on each contribution, count up to the limit otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TableSize; i++) wait_reg[i] <= 8'd0;
    end else begin
      for (int i = 0; i < TableSize; i++) begin
        if (!act_final[i] || (touched && (idx == IdxW'(i))))
          wait_reg[i] <= 8'd0;
        else if (wait_reg[i] < TimeoutLimit)
          wait_reg[i] <= wait_reg[i] + 8'd1;
      end
    end
  end
`else
  localparam int unused_timeout = TimeoutCycles;

  // Without the timeout feature entries wait indefinitely
  always_comb begin
    to_fire   = 1'b0;
    to_flit   = '0;
    act_final = act_next;
  end
`endif

  // Table state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_reg <= '0;
      for (int i = 0; i < TableSize; i++) begin
        tag_reg[i] <= '0;
        op_reg[i]  <= '0;
        alg_reg[i] <= '0;
        ctx_reg[i] <= '0;
        acc_reg[i] <= '0;
        rem_reg[i] <= '0;
      end
    end else begin
      act_reg <= act_final;
      tag_reg <= tag_next;
      op_reg  <= op_next;
      alg_reg <= alg_next;
      ctx_reg <= ctx_next;
      acc_reg <= acc_next;
      rem_reg <= rem_next;
    end
  end

  // Single output register plus the one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      err       <= 1'b0;
    end else begin
      err <= tag_drop | to_fire;
      if (done) begin
        out_valid <= 1'b1;
        out_flit  <= done_flit;
      end else if (to_fire) begin
        out_valid <= 1'b1;
        out_flit  <= to_flit;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
